// File: rtl/cmac_tx_pkt_fifo.sv
// cmac_tx_pkt_fifo: store-and-forward AXIS packet buffer, ERNIC TX -> CMAC TX; oversize packets dropped. Optional counters: CMAC_TX_PKT_FIFO_STATS_EN.
// Latency: ingress tlast accepted in cycle N -> first egress beat valid in cycle N+2 when egress is idle.
// Backpressure: s_axis_tready low when RAM full or MAX_PKTS held; m_axis_tready stalls absorbed by a 2-entry skid, packets leave gap-free.
module cmac_tx_pkt_fifo #(
  parameter int DEPTH    = 64,
  parameter int MAX_PKTS = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [511:0]                s_axis_tdata,
  input  logic [63:0]                 s_axis_tkeep,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [511:0]                m_axis_tdata,
  output logic [63:0]                 m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic [$clog2(MAX_PKTS):0]   pkt_cnt,
  output logic                        drop_pulse
`ifdef CMAC_TX_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]                 stat_tx_pkts,
  output logic [47:0]                 stat_tx_bytes,
  output logic [15:0]                 stat_drop_pkts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKTS) + 1;
  localparam int BW = 512 + 64 + 1;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;

  wstate_t        w_state, w_nxt;
  logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr, used;
  logic           full, rdy_en, w_rdy, acc;
  logic           wr_en, commit, drop_go, drop_end;
  logic [BW-1:0]  mem [DEPTH];
  logic [BW-1:0]  rd_word, e0, e1;
  logic [1:0]     occ, k;
  logic           pop, issue, retire;

  assign used = wr_ptr - rd_ptr;
  assign full = (used == PW'(DEPTH));

  // write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_nxt;
  end

  // write FSM next state: a packet in progress either commits on tlast or, if it alone fills the RAM, is dropped
  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_en && !s_axis_tlast) w_nxt = W_PKT;
      W_PKT:   if (commit) w_nxt = W_IDLE;
               else if (drop_go) w_nxt = W_DROP;
      W_DROP:  if (drop_end) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  // write FSM outputs: ingress ready and the write/commit/drop strobes
  always_comb begin
    w_rdy   = 1'b0;
    drop_go = 1'b0;
    case (w_state)
      W_IDLE:  w_rdy = (pkt_cnt != CW'(MAX_PKTS)) && !full;
      W_PKT:   begin
                 w_rdy   = !full;
                 drop_go = full && (commit_ptr == rd_ptr);
               end
      W_DROP:  w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
    s_axis_tready = w_rdy & rdy_en;
    acc           = s_axis_tvalid & s_axis_tready;
    wr_en         = acc && (w_state != W_DROP);
    commit        = wr_en && s_axis_tlast;
    drop_end      = acc && s_axis_tlast && (w_state == W_DROP);
  end

  // data RAM write port; contents need no reset since pointers define validity
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // write/commit pointers, packet count, drop pulse and ready-after-reset enable
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_cnt    <= '0;
      drop_pulse <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      drop_pulse <= drop_end;
      if (wr_en)        wr_ptr <= wr_ptr + PW'(1);
      else if (drop_go) wr_ptr <= commit_ptr;
      if (commit) commit_ptr <= wr_ptr + PW'(1);
      case ({commit, retire})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Read side: only committed (complete) packets are ever read, so streaming
  // every committed beat back-to-back keeps each packet contiguous on egress.
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign retire  = pop & m_axis_tlast;
  assign k       = occ - {1'b0, pop};
  assign issue   = (commit_ptr != rd_ptr) && (k != 2'd2);

  // registered RAM read lands directly in the output stage (e0) or the skid (e1)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occ    <= '0;
      e0     <= '0;
      e1     <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop && occ == 2'd2) e0 <= e1;
      if (issue) begin
        if (k == 2'd0) e0 <= rd_word;
        else           e1 <= rd_word;
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= k + {1'b0, issue};
    end
  end

  assign m_axis_tdata  = e0[511:0];
  assign m_axis_tkeep  = e0[575:512];
  assign m_axis_tlast  = e0[576];
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tuser  = 1'b0;

`ifdef CMAC_TX_PKT_FIFO_STATS_EN
  // free-running wrap-around statistics
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_tx_pkts   <= '0;
      stat_tx_bytes  <= '0;
      stat_drop_pkts <= '0;
    end else begin
      if (retire)     stat_tx_pkts   <= stat_tx_pkts + 32'd1;
      if (pop)        stat_tx_bytes  <= stat_tx_bytes + 48'($countones(m_axis_tkeep));
      if (drop_pulse) stat_drop_pkts <= stat_drop_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmac_tx_pkt_fifo.sv
// tb_cmac_tx_pkt_fifo: directed bench for the store-and-forward CMAC TX packet buffer.
// Latency: egress monitor samples on the falling edge; stimulus driven 1 ns after the rising edge.
// Backpressure: m_axis_tready driven per scenario; every wait on the DUT is cycle-bounded.
module tb_cmac_tx_pkt_fifo;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic         m_axis_tready;
  logic [4:0]   pkt_cnt;
  logic         drop_pulse;

  int checks = 0;
  int errors = 0;
  int gaps   = 0;
  int drops  = 0;
  logic in_pkt = 1'b0;
  logic [511:0] cap_dat[$];
  logic [63:0]  cap_keep[$];
  logic         cap_last[$];

  always #5 aclk = ~aclk;

  cmac_tx_pkt_fifo #(.DEPTH(64), .MAX_PKTS(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt), .drop_pulse(drop_pulse)
  );

  // egress capture, intra-packet gap detection and drop pulse counting
  always @(negedge aclk) begin
    if (!aresetn) begin
      in_pkt = 1'b0;
    end else begin
      if (drop_pulse) drops++;
      if (in_pkt && m_axis_tready && !m_axis_tvalid) gaps++;
      if (m_axis_tvalid && m_axis_tready) begin
        cap_dat.push_back(m_axis_tdata);
        cap_keep.push_back(m_axis_tkeep);
        cap_last.push_back(m_axis_tlast);
        in_pkt = !m_axis_tlast;
      end
    end
  end

  function automatic logic [511:0] mkdat(input int id, input int b);
    return {16{id[15:0], b[15:0]}};
  endfunction

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] kp, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = kp;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=no_ready expected=ready");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int id, input int n, input logic [63:0] lastkeep, input bit gap);
    for (int b = 0; b < n; b++) begin
      send_beat(mkdat(id, b), (b == n - 1) ? lastkeep : {64{1'b1}}, b == n - 1);
      if (gap && b != n - 1) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pkt_cnt != 0 || m_axis_tvalid) && n < 500) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $error("FAIL idle_timeout observed=pkt_cnt_%0d expected=0", pkt_cnt);
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_beats(input string tag, input int idx, input int id, input int n, input logic [63:0] lastkeep);
    for (int b = 0; b < n; b++) begin
      if (idx + b < cap_dat.size()) begin
        chk({tag, "_data"}, cap_dat[idx+b], mkdat(id, b));
        chk({tag, "_keep"}, cap_keep[idx+b], (b == n - 1) ? lastkeep : {64{1'b1}});
        chk({tag, "_last"}, cap_last[idx+b], b == n - 1);
      end
    end
  endtask

  initial begin
    int base;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop", drop_pulse, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_s_tready", s_axis_tready, 1);

    // 1: 9-beat 522-byte packet, latency and contiguity
    base = cap_dat.size();
    send_pkt(1, 9, 64'h3FF, 1'b0);
    chk("t1_cnt_commit", pkt_cnt, 1);
    chk("t1_vld_n1", m_axis_tvalid, 0);
    @(posedge aclk);
    #1;
    chk("t1_vld_n2", m_axis_tvalid, 1);
    chk("t1_first_data", m_axis_tdata, mkdat(1, 0));
    wait_idle();
    chk("t1_cnt_done", pkt_cnt, 0);
    chk("t1_nbeats", cap_dat.size() - base, 9);
    check_beats("t1", base, 1, 9, 64'h3FF);
    chk("t1_gaps", gaps, 0);

    // 2: gappy ingress, gap-free egress
    base = cap_dat.size();
    send_pkt(2, 9, 64'h3FF, 1'b1);
    wait_idle();
    chk("t2_nbeats", cap_dat.size() - base, 9);
    check_beats("t2", base, 2, 9, 64'h3FF);
    chk("t2_gaps", gaps, 0);

    // 3: 80-beat oversize packet dropped, following 1-beat packet intact
    base = cap_dat.size();
    send_pkt(3, 80, {64{1'b1}}, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    chk("t3_drops", drops, 1);
    chk("t3_no_egress", cap_dat.size() - base, 0);
    chk("t3_cnt", pkt_cnt, 0);
    send_pkt(4, 1, {64{1'b1}}, 1'b0);
    wait_idle();
    chk("t3_next_nbeats", cap_dat.size() - base, 1);
    check_beats("t3_next", base, 4, 1, {64{1'b1}});

    // 4: packet-count limit with egress stalled
    m_axis_tready = 1'b0;
    base = cap_dat.size();
    for (int i = 0; i < 16; i++) send_pkt(100 + i, 1, {64{1'b1}}, 1'b0);
    chk("t4_cnt_full", pkt_cnt, 16);
    chk("t4_s_tready", s_axis_tready, 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("t4_s_tready_hold", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    send_pkt(116, 1, {64{1'b1}}, 1'b0);
    wait_idle();
    chk("t4_nbeats", cap_dat.size() - base, 17);
    for (int i = 0; i < 17; i++) check_beats("t4", base + i, 100 + i, 1, {64{1'b1}});

    // 5: steady 1-beat stream, commit and retire every cycle
    base = cap_dat.size();
    for (int i = 0; i < 20; i++) begin
      send_pkt(300 + i, 1, {64{1'b1}}, 1'b0);
      if (i == 5 || i == 15) chk("t5_cnt_steady", pkt_cnt, 2);
    end
    wait_idle();
    chk("t5_nbeats", cap_dat.size() - base, 20);
    for (int i = 0; i < 20; i++) check_beats("t5", base + i, 300 + i, 1, {64{1'b1}});
    chk("t5_gaps", gaps, 0);

    // 6: reset with both sides mid-packet
    m_axis_tready = 1'b0;
    send_pkt(400, 8, {64{1'b1}}, 1'b0);
    m_axis_tready = 1'b1;
    send_beat(mkdat(401, 0), {64{1'b1}}, 1'b0);
    send_beat(mkdat(401, 1), {64{1'b1}}, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_m_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_m_tdata", m_axis_tdata, 0);
    chk("t6_rst_pkt_cnt", pkt_cnt, 0);
    chk("t6_rst_s_tready", s_axis_tready, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("t6_post_s_tready", s_axis_tready, 1);
    base = cap_dat.size();
    send_pkt(402, 2, 64'h0F, 1'b0);
    wait_idle();
    repeat (5) @(posedge aclk);
    #1;
    chk("t6_nbeats", cap_dat.size() - base, 2);
    check_beats("t6", base, 402, 2, 64'h0F);
    chk("t6_drops_total", drops, 1);
    chk("t6_tuser", m_axis_tuser, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmac_tx_pkt_fifo.md
Name: cmac_tx_pkt_fifo

Overview:
Store-and-forward AXI4-Stream packet buffer between the ERNIC TX stream output and the CMAC TX AXIS input (via the packet-gen/mux stage). It accepts 512-bit beats with arbitrary source gaps and releases a packet only after its tlast is stored. Each released packet is then driven to CMAC in back-to-back beats, so the MAC never sees an intra-packet tvalid gap (tx_unfout). Packets larger than the buffer are dropped, not deadlocked.

Parameters:
DEPTH, 64, data RAM depth in 512-bit beats (power of 2, >=16)
MAX_PKTS, 16, max committed packets held (power of 2)

Ports:
aclk  in  1  single clock (CMAC txusrclk2 domain)
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  512  ingress data
s_axis_tkeep  in  64  ingress byte enables, contiguous LSB-first
s_axis_tvalid  in  1  ingress valid
s_axis_tlast  in  1  ingress end of packet
s_axis_tready  out  1  ingress ready
m_axis_tdata  out  512  egress data
m_axis_tkeep  out  64  egress byte enables
m_axis_tvalid  out  1  egress valid
m_axis_tlast  out  1  egress end of packet
m_axis_tuser  out  1  egress error flag, tied 0
m_axis_tready  in  1  egress ready from CMAC
pkt_cnt  out  $clog2(MAX_PKTS)+1  committed packets not yet fully sent
drop_pulse  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset (async assert, sync release): all pointers and counters 0. Write FSM = W_IDLE, read FSM = R_IDLE. Outputs: s_axis_tready 0 while in reset, 1 on the first cycle after; m_axis_* 0; pkt_cnt 0; drop_pulse 0. Any partial or stored packets are discarded.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits with wrap bit. used = wr_ptr - rd_ptr (modulo). full = (used == DEPTH).
- Write FSM:
  - W_IDLE: wait for first beat. If pkt_cnt==MAX_PKTS, s_axis_tready=0. Otherwise tready=!full. On an accepted beat: write RAM, wr_ptr++. If tlast is also set, commit; else go to W_PKT.
  - W_PKT: tready=!full.
    - Accepted tlast: commit_ptr<=wr_ptr+1, pkt_cnt++, go to W_IDLE.
    - Drop condition: full and commit_ptr==rd_ptr (in-progress packet fills the whole buffer). Then wr_ptr<=commit_ptr and go to W_DROP. Committed data is untouched.
  - W_DROP: s_axis_tready=1, beats are discarded. On accepted tlast: drop_pulse=1 for one cycle, go to W_IDLE.
- Read FSM (RAM 1-cycle read latency plus output register):
  - R_IDLE: when pkt_cnt>0 and the output register is empty/consumed, prefetch the head beat.
  - R_PKT: m_axis_tvalid stays high from the first beat through tlast while m_axis_tready=1. A 2-entry skid guarantees no bubble after tready deasserts and reasserts.
  - On m_axis tlast handshake: pkt_cnt--. If pkt_cnt>0, the next packet follows with no idle cycle.
- Latency: ingress tlast accepted in cycle N -> commit visible N+1 -> m_axis_tvalid with first beat at N+2 when the egress is idle and m_axis_tready=1.
- Commit and retire in the same cycle: pkt_cnt unchanged.
- Data and tkeep pass through bit-exact. tkeep is not checked.
- Throughput: 1 beat/cycle both sides sustained.

Optional Feature:
CMAC_TX_PKT_FIFO_STATS_EN
- Defined: adds outputs stat_tx_pkts[31:0], stat_tx_bytes[47:0] and stat_drop_pkts[15:0].
  - stat_tx_pkts increments on each egress tlast handshake.
  - stat_tx_bytes adds popcount(tkeep) on every egress handshake.
  - stat_drop_pkts increments on each drop_pulse.
  - All counters reset to 0 and wrap silently.
- Undefined: these ports and all associated logic are absent.

Test Plan:
- Single 522-byte packet (9 beats, last tkeep=64'h3FF), m_axis_tready=1 -> m_axis_tvalid rises 2 cycles after ingress tlast. Output is 9 contiguous beats, last tkeep 64'h3FF, data identical. pkt_cnt goes 0->1->0.
- Same packet with s_axis_tvalid toggling every other cycle -> egress still 9 back-to-back beats with no tvalid gap.
- DEPTH=64, empty buffer, 80-beat packet -> exactly one drop_pulse at its tlast and no egress beats. A following 64-byte packet (1 beat, tkeep all ones) is output correctly.
- m_axis_tready=0, push 17 one-beat packets -> s_axis_tready=0 after the 16th commit, pkt_cnt=16. After tready=1 all 17 packets emerge in order.
- Steady stream of 1-beat packets with commit and retire every cycle -> pkt_cnt stays constant, no lost or duplicate beats.
- aresetn asserted mid-packet on both sides -> outputs 0 immediately, pkt_cnt 0. After release a fresh packet passes and no stale beats appear.
